// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and select width.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_SLL   = 4'h5,
        ALU_SRL   = 4'h6,
        ALU_SRA   = 4'h7,
        ALU_SLT   = 4'h8,
        ALU_SLTU  = 4'h9,
        ALU_PASSB = 4'hA
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath; reserved opcodes produce zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [ALU_OP_W-1:0]   op_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int unsigned ShW = $clog2(DATA_WIDTH);

    // Only the low bits of rs2 select the shift distance.
    logic [ShW-1:0] sh;
    logic           lt_signed;
    logic           lt_unsigned;

    assign sh          = rs2_i[ShW-1:0];
    assign lt_signed   = $signed(rs1_i) < $signed(rs2_i);
    assign lt_unsigned = rs1_i < rs2_i;

    // Operation decode; every path writes result_o, reserved codes fall to zero.
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:   result_o = rs1_i + rs2_i;
            ALU_SUB:   result_o = rs1_i - rs2_i;
            ALU_AND:   result_o = rs1_i & rs2_i;
            ALU_OR:    result_o = rs1_i | rs2_i;
            ALU_XOR:   result_o = rs1_i ^ rs2_i;
            ALU_SLL:   result_o = rs1_i << sh;
            ALU_SRL:   result_o = rs1_i >> sh;
            ALU_SRA:   result_o = $unsigned($signed(rs1_i) >>> sh);
            ALU_SLT:   result_o = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
            ALU_SLTU:  result_o = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
            ALU_PASSB: result_o = rs2_i;
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_unit_hw.sv
// Registered execute-stage ALU: one op per cycle, result and zero flag one edge later.
module alu_unit_hw
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic [ALU_OP_W-1:0]   aluControl,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  zero
);

    logic [DATA_WIDTH-1:0] rd_d;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  zero_d;
    logic                  zero_q;

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu_core (
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .op_i     (aluControl),
        .result_o (rd_d)
    );

    // Zero flag comes from the same next-state value so it can never disagree with rd.
    always_comb begin
        zero_d = (rd_d == '0);
    end

    // Result/flag registers; reset takes priority over the op presented that cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_q   <= '0;
            zero_q <= 1'b1;
        end else begin
            rd_q   <= rd_d;
            zero_q <= zero_d;
        end
    end

    assign rd   = rd_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_alu_unit_hw.sv
// Scoreboard bench for alu_unit_hw: driver pushes expectations, monitor pops and compares.
module tb_alu_unit_hw;

    localparam int unsigned W = 32;

    logic         clock;
    logic         reset_n;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic [3:0]   aluControl;
    logic [W-1:0] rd;
    logic         zero;

    alu_unit_hw #(
        .DATA_WIDTH (W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rs1        (rs1),
        .rs2        (rs2),
        .aluControl (aluControl),
        .rd         (rd),
        .zero       (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] rd;
        logic         zero;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    // Reference: ALU rules written with plain arithmetic on 32-bit values.
    function automatic logic [W-1:0] ref_alu(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] op);
        int unsigned sh;
        logic [W-1:0] fill;
        sh = b % 32;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << sh;
            4'h6: return a >> sh;
            4'h7: begin
                fill = a[W-1] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
                return (a >> sh) | fill;
            end
            // Bias by 2^31 turns a signed order into an unsigned one.
            4'h8: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
            4'hA: return b;
            default: return 32'h0;
        endcase
    endfunction

    // Drive one cycle of stimulus on the falling edge and record what must appear after the next rise.
    task automatic issue(input logic rst_n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op, input logic [W-1:0] exp_rd, input string nm);
        exp_t e;
        @(negedge clock);
        reset_n    = rst_n;
        rs1        = a;
        rs2        = b;
        aluControl = op;
        e.rd   = rst_n ? exp_rd : '0;
        e.zero = rst_n ? (exp_rd == '0) : 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic issue_rand(input logic rst_n, input string nm);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        a  = $urandom;
        b  = $urandom;
        op = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 7))
            0: a = 32'hFFFF_FFFF;
            1: a = 32'h8000_0000;
            2: b = a;
            3: b = 32'($urandom_range(0, 40));
            default: ;
        endcase
        issue(rst_n, a, b, op, ref_alu(a, b, op), nm);
    endtask

    // Monitor: output is valid every cycle once stimulus starts; compare just after each rise.
    always @(posedge clock) begin
        exp_t  e;
        string nm;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (rd !== e.rd || zero !== e.zero) begin
                n_err++;
                $display("FAIL %s: got rd=%h zero=%b, expected rd=%h zero=%b",
                         nm, rd, zero, e.rd, e.zero);
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        rs1        = '0;
        rs2        = '0;
        aluControl = 4'h0;

        issue(1'b0, 32'd5, 32'd1, 4'h0, 32'h0, "reset0");
        issue(1'b0, 32'd5, 32'd1, 4'h0, 32'h0, "reset1");
        issue(1'b1, 32'd5, 32'd1, 4'h0, 32'h0000_0006, "add_5_1");
        issue(1'b1, 32'd1, 32'd6, 4'h1, 32'hFFFF_FFFB, "sub_1_6");
        issue(1'b1, 32'd7, 32'd7, 4'h1, 32'h0, "sub_7_7");
        issue(1'b1, 32'h1, 32'h24, 4'h5, 32'h10, "sll_sh_masked");
        issue(1'b1, 32'h8000_0000, 32'd4, 4'h6, 32'h0800_0000, "srl");
        issue(1'b1, 32'h8000_0000, 32'd4, 4'h7, 32'hF800_0000, "sra");
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 4'h8, 32'h1, "slt");
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 4'h9, 32'h0, "sltu");
        issue(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h2, 32'hF000_F000, "and");
        issue(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h3, 32'hFFF0_FFF0, "or");
        issue(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h4, 32'h0FF0_0FF0, "xor");
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 4'h0, 32'h0, "add_wrap");
        issue(1'b1, 32'hDEAD_BEEF, 32'h1234, 4'hA, 32'h1234, "passb");
        issue(1'b1, 32'hDEAD_BEEF, 32'h1234, 4'hC, 32'h0, "reserved_c");
        issue(1'b1, 32'h8000_0000, 32'd31, 4'h7, 32'hFFFF_FFFF, "sra_31");
        issue(1'b1, 32'h0000_0005, 32'h20, 4'h5, 32'h5, "sll_sh_zero");

        // Back-to-back random ops with an occasional mid-stream reset.
        for (int i = 0; i < 300; i++) begin
            issue_rand(($urandom_range(0, 24) != 0), "random");
        end
        issue_rand(1'b0, "reset_midstream");
        issue_rand(1'b1, "after_reset");

        repeat (3) @(negedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
